fifo_rr_push_arbiter: RTL and testbench

// - Shares the write port of one mxv_pkg FIFO among N_REQ producers.
// - Round-robin arbitration; a granted producer keeps the port for a burst of up to BURST_LEN words.
// - Sits between the matrix/vector producer lanes and the FIFO push/DataInput/full ports.
// - Honours FIFO back-pressure (full) without losing or duplicating words.

---
 rtl/mxv_pkg.sv | 9 +
 rtl/fifo_rr_push_arbiter_if.sv | 25 ++
 rtl/fifo_rr_push_arbiter_rr_grant_picker.sv | 22 ++
 rtl/fifo_rr_push_arbiter.sv | 67 ++++++
 tb/tb_fifo_rr_push_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mxv_pkg.sv
// mxv_pkg: shared FIFO geometry plus the push-arbiter constants and types.
package mxv_pkg;
    localparam int DW_FIFO        = 16;
    localparam int AW_FIFO        = 4;
    localparam int N_REQ_FIFO     = 4;
    localparam int BURST_LEN_FIFO = 4;
    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;
    typedef logic [$clog2(N_REQ_FIFO)-1:0] req_id_t;
endpackage

// File: rtl/fifo_rr_push_arbiter_if.sv
// fifo_rr_push_arbiter_if: producer lanes and FIFO write port around the push arbiter.
interface fifo_rr_push_arbiter_if
    import mxv_pkg::*;
#(
    parameter int N_REQ = N_REQ_FIFO
) ();
    localparam int W = $clog2(N_REQ);
    logic [N_REQ-1:0]              req_i;
    logic [N_REQ-1:0][DW_FIFO-1:0] data_i;
    logic [N_REQ-1:0]              ack_o;
    logic [N_REQ-1:0]              grant_o;
    logic [W-1:0]                  owner_o;
    logic                          busy_o;
    logic                          fifo_full;
    logic                          fifo_push;
    logic [DW_FIFO-1:0]            fifo_data;
    modport master (
        input  req_i, data_i, fifo_full,
        output ack_o, grant_o, owner_o, busy_o, fifo_push, fifo_data
    );
    modport slave (
        output req_i, data_i, fifo_full,
        input  ack_o, grant_o, owner_o, busy_o, fifo_push, fifo_data
    );
endinterface

// File: rtl/fifo_rr_push_arbiter_rr_grant_picker.sv
// rr_grant_picker: first set request bit at or after start, wrapping modulo N.
module rr_grant_picker #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] win
);
    // Walk from the farthest slot back to start so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                found = 1'b1;
                win   = W'((int'(start) + k) % N);
            end
        end
    end
endmodule

// File: rtl/fifo_rr_push_arbiter.sv
// fifo_rr_push_arbiter: round-robin, burst-limited sharing of one FIFO write port.
module fifo_rr_push_arbiter
    import mxv_pkg::*;
#(
    parameter int N_REQ     = N_REQ_FIFO,
    parameter int BURST_LEN = BURST_LEN_FIFO
) (
    input logic                  clk,
    input logic                  rst,
    fifo_rr_push_arbiter_if.master bus
);
    localparam int W  = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_LEN) + 1;
    arb_state_t       state_q, state_n;
    logic [W-1:0]     owner_q, owner_n, ptr_q, ptr_n, start, win;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [N_REQ-1:0] grant_q, grant_n, owner_oh, pick_req;
    logic             own, oreq, accept, rel, found;
    assign own      = state_q == ARB_OWN;
    assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign oreq     = bus.req_i[owner_q];
    assign accept   = own & oreq & ~bus.fifo_full;
    assign rel      = own & (~oreq | (accept & (cnt_q == CW'(BURST_LEN - 1))));
    // On release the search restarts just past the owner; a dropped owner may not re-win.
    assign start    = !rel ? ptr_q : (owner_q == W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign pick_req = (rel & ~oreq) ? bus.req_i & ~owner_oh : bus.req_i;
    rr_grant_picker #(.N(N_REQ)) u_picker (
        .req  (pick_req),
        .start(start),
        .found(found),
        .win  (win)
    );
    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        cnt_n   = accept ? cnt_q + 1'b1 : cnt_q;
        if (!own || rel) begin
            ptr_n   = start;
            state_n = found ? ARB_OWN : ARB_IDLE;
            owner_n = found ? win : '0;
            cnt_n   = '0;
        end
        grant_n = (state_n == ARB_OWN) ? {{(N_REQ-1){1'b0}}, 1'b1} << owner_n : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
            grant_q <= grant_n;
        end
    end
    assign bus.ack_o     = accept ? owner_oh : '0;
    assign bus.fifo_push = accept;
    assign bus.fifo_data = own ? bus.data_i[owner_q] : '0;
    assign bus.grant_o   = grant_q;
    assign bus.owner_o   = owner_q;
    assign bus.busy_o    = own;
endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// tb_fifo_rr_push_arbiter: directed scenarios with a scoreboard of expected FIFO words.
module tb_fifo_rr_push_arbiter;
    import mxv_pkg::*;
    logic clk, rst;
    fifo_rr_push_arbiter_if #(.N_REQ(4)) bus ();
    fifo_rr_push_arbiter #(.N_REQ(4), .BURST_LEN(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int          n_chk, n_err, n_ack;
    int          rem[4], seq[4], exp_seq[4];
    logic [15:0] sb[$];
    logic [31:0] hist, exp_w;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic expect_word(input int p);
        sb.push_back({4'(p), 12'(exp_seq[p])});
        exp_seq[p]++;
    endtask
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.req_i[i]  = rem[i] > 0;
            bus.data_i[i] = {4'(i), 12'(seq[i])};
        end
    endtask
    // Producers hold their word until acked, then advance; outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        hist = {hist[30:0], bus.fifo_push};
        if (bus.fifo_push) begin
            exp_w = sb.size() > 0 ? {16'h0, sb.pop_front()} : 32'hffff_ffff;
            chk("push_data", {16'h0, bus.fifo_data}, exp_w);
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.ack_o[i]) begin
                seq[i]++;
                rem[i]--;
                n_ack++;
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    initial begin
        n_chk = 0; n_err = 0; n_ack = 0; hist = '0;
        for (int i = 0; i < 4; i++) begin rem[i] = 0; seq[i] = 0; exp_seq[i] = 0; end
        // Reset with random requests, then the first grant goes to producer 0.
        rst = 1'b1;
        bus.fifo_full = 1'b0;
        drive();
        bus.req_i = 4'($urandom);
        @(negedge clk);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_push", bus.fifo_push, 0);
        chk("rst_ack", bus.ack_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_data", bus.fifo_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rem[i] = 1;
        drive();
        tick();
        chk("t1_first_grant", bus.grant_o, 4'b0001);
        chk("t1_owner", bus.owner_o, 0);
        for (int i = 0; i < 4; i++) rem[i] = 0;
        drive();
        tick();
        chk("t1_no_push_on_drop", hist[0], 0);
        chk("t1_idle", bus.busy_o, 0);
        // Sole requester 2 for 6 words: 4 + 2 with immediate re-grant.
        hist = '0;
        rem[2] = 6;
        drive();
        for (int k = 0; k < 6; k++) expect_word(2);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) chk("t2_grant", bus.grant_o, 4'b0100);
            if (k == 5) chk("t2_regrant", bus.grant_o, 4'b0100);
        end
        chk("t2_pattern", hist & 32'h1ff, 32'h0fc);
        chk("t2_acks", n_ack, 6);
        chk("t2_idle", bus.busy_o, 0);
        // All four requesting: owners 0,1,2,3,0 with full bursts.
        do_reset();
        hist = '0;
        for (int i = 0; i < 4; i++) rem[i] = 100;
        drive();
        for (int p = 0; p < 5; p++) for (int k = 0; k < 4; k++) expect_word(p % 4);
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 1) chk("t3_grant0", bus.grant_o, 4'b0001);
            if (k == 9) chk("t3_grant2", bus.grant_o, 4'b0100);
            if (k == 17) chk("t3_wrap0", bus.grant_o, 4'b0001);
        end
        chk("t3_pattern", hist & 32'h1fffff, 32'h0fffff);
        chk("t3_next_owner", bus.grant_o, 4'b0010);
        for (int i = 0; i < 4; i++) rem[i] = 0;
        drive();
        tick();
        chk("t3_idle", bus.busy_o, 0);
        // Producer 1 stalled by full for 3 cycles after its second word.
        do_reset();
        hist = '0;
        rem[1] = 4;
        drive();
        for (int k = 0; k < 4; k++) expect_word(1);
        tick();
        chk("t4_grant", bus.grant_o, 4'b0010);
        tick();
        tick();
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_grant_held", bus.grant_o, 4'b0010);
        end
        bus.fifo_full = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("t4_pattern", hist & 32'h1ff, 32'h0c6);
        chk("t4_idle", bus.busy_o, 0);
        // Producer 0 drops after 2 words; pending producer 3 takes over next cycle.
        do_reset();
        hist = '0;
        rem[0] = 2;
        rem[3] = 1;
        drive();
        expect_word(0);
        expect_word(0);
        expect_word(3);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) chk("t5_grant3", bus.grant_o, 4'b1000);
        end
        chk("t5_pattern", hist & 32'h3f, 32'h1a);
        chk("t5_idle", bus.busy_o, 0);
        // Async reset mid-burst: pending word dropped, producer retries after restart.
        do_reset();
        rem[2] = 100;
        drive();
        expect_word(2);
        expect_word(2);
        tick();
        tick();
        tick();
        #2;
        chk("t6_push_pre_rst", bus.fifo_push, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_push", bus.fifo_push, 0);
        chk("t6_rst_ack", bus.ack_o, 0);
        chk("t6_rst_grant", bus.grant_o, 0);
        chk("t6_rst_busy", bus.busy_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rem[0] = 1;
        rem[2] = 1;
        drive();
        expect_word(0);
        expect_word(2);
        tick();
        chk("t6_restart_ptr0", bus.grant_o, 4'b0001);
        for (int k = 0; k < 4; k++) tick();
        chk("t6_idle", bus.busy_o, 0);
        chk("sb_empty", sb.size(), 0);
        chk("total_acks", n_ack, 37);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
